// File: rtl/ram_arb_pkg.sv
// Shared constants and types for the ram1 two-client arbiter.
// Client IDs are one bit: 0 = port 0, 1 = port 1.
package ram_arb_pkg;
   localparam int DW    = 8;
   localparam int AW    = 6;
   localparam int DEPTH = 2 ** AW;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_t;

   typedef logic client_id_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: a lone request wins outright, and under contention
// the client that was not granted most recently wins. The grant is one-hot or zero.
module rr_arb2
   import ram_arb_pkg::*;
(
   input  logic [1:0] req,
   input  client_id_t last,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = req;
      if (req == 2'b11) begin
         gnt = (last == 1'b1) ? 2'b01 : 2'b10;
      end
   end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter/sequencer sharing single-port ram1 between two clients.
// Reads return one cycle after grant; RAM_ARB_CLEAR_EN adds a post-reset clear of all words.
module ram_arbiter #(
   parameter int              DW      = ram_arb_pkg::DW,
   parameter int              AW      = ram_arb_pkg::AW,
   parameter logic [DW-1:0]   CLR_VAL = '0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req0,
   input  logic          req1,
   input  logic          we0,
   input  logic          we1,
   input  logic [AW-1:0] addr0,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata0,
   input  logic [DW-1:0] wdata1,
   output logic          gnt0,
   output logic          gnt1,
   output logic          rvalid0,
   output logic          rvalid1,
   output logic [DW-1:0] rdata,
   output logic [DW-1:0] ram_ip,
   output logic [AW-1:0] ram_add,
   output logic          ram_wr,
   input  logic [DW-1:0] ram_q,
   output logic          busy
);

   logic [1:0]              arb_gnt;
   logic [1:0]              gnt_v;
   logic                    clearing;
   logic [AW-1:0]           count_q;
   ram_arb_pkg::client_id_t last_q, last_d;
   ram_arb_pkg::client_id_t owner_q, owner_d;
   logic                    rd_vld_q, rd_vld_d;

`ifdef RAM_ARB_CLEAR_EN
   ram_arb_pkg::state_t state_q, state_d;
   logic [AW-1:0]       count_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ram_arb_pkg::CLEAR;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      if (state_q == ram_arb_pkg::CLEAR) begin
         count_d = count_q + 1'b1;
         if (count_q == {AW{1'b1}}) begin
            state_d = ram_arb_pkg::RUN;
         end
      end
   end

   assign clearing = (state_q == ram_arb_pkg::CLEAR);
`else
   assign clearing = 1'b0;
   assign count_q  = '0;
`endif

   rr_arb2 u_rr_arb2 (
      .req  ({req1, req0}),
      .last (last_q),
      .gnt  (arb_gnt)
   );

   always_comb begin
      gnt_v    = '0;
      ram_wr   = 1'b0;
      ram_add  = addr0;
      ram_ip   = wdata0;
      busy     = 1'b0;
      last_d   = last_q;
      owner_d  = owner_q;
      rd_vld_d = 1'b0;

      if (rst_n && !clearing) begin
         gnt_v = arb_gnt;
      end

      if (clearing) begin
         ram_wr  = rst_n;
         ram_add = count_q;
         ram_ip  = CLR_VAL;
         busy    = rst_n;
      end else if (gnt_v[1]) begin
         ram_wr  = we1;
         ram_add = addr1;
         ram_ip  = wdata1;
      end else if (gnt_v[0]) begin
         ram_wr  = we0;
      end

      // Owner tag follows every grant; only reads raise the return strobe.
      if (gnt_v[1]) begin
         last_d   = 1'b1;
         owner_d  = 1'b1;
         rd_vld_d = ~we1;
      end else if (gnt_v[0]) begin
         last_d   = 1'b0;
         owner_d  = 1'b0;
         rd_vld_d = ~we0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_q   <= 1'b1;
         owner_q  <= 1'b0;
         rd_vld_q <= 1'b0;
      end else begin
         last_q   <= last_d;
         owner_q  <= owner_d;
         rd_vld_q <= rd_vld_d;
      end
   end

   // Gated by rst_n so a read granted just before reset never returns.
   assign gnt0    = gnt_v[0];
   assign gnt1    = gnt_v[1];
   assign rvalid0 = rd_vld_q & ~owner_q & rst_n;
   assign rvalid1 = rd_vld_q &  owner_q & rst_n;
   assign rdata   = ram_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural ram1 model (registered read port).
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_ram_arbiter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req0, req1, we0, we1;
   logic [5:0] addr0, addr1;
   logic [7:0] wdata0, wdata1;
   logic       gnt0, gnt1, rvalid0, rvalid1;
   logic [7:0] rdata, ram_ip, ram_q;
   logic [5:0] ram_add;
   logic       ram_wr, busy;

   int checks = 0;
   int errors = 0;

   logic [7:0] mem [64];

   always #5 clk = ~clk;

   always @(posedge clk) begin
      ram_q <= mem[ram_add];
      if (ram_wr) mem[ram_add] <= ram_ip;
   end

   ram_arbiter dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req0    (req0),
      .req1    (req1),
      .we0     (we0),
      .we1     (we1),
      .addr0   (addr0),
      .addr1   (addr1),
      .wdata0  (wdata0),
      .wdata1  (wdata1),
      .gnt0    (gnt0),
      .gnt1    (gnt1),
      .rvalid0 (rvalid0),
      .rvalid1 (rvalid1),
      .rdata   (rdata),
      .ram_ip  (ram_ip),
      .ram_add (ram_add),
      .ram_wr  (ram_wr),
      .ram_q   (ram_q),
      .busy    (busy)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
   endtask

   task automatic do_reset();
      int n;
      rst_n = 1'b0;
      idle_inputs();
      step();
      step();
      rst_n = 1'b1;
      n = 0;
      @(negedge clk);
      while (busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_exit: busy=%b after %0d cycles, required 0", busy, n);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle_inputs();
      req0 = 1'b1; req1 = 1'b1; we0 = 1'b1; we1 = 1'b1;
      step();
      step();
      @(negedge clk);
      checks++;
      if ({gnt0, gnt1, rvalid0, rvalid1, ram_wr, busy} !== 6'b0) begin
         errors++;
         $display("FAIL reset_state: gnt0/gnt1/rvalid0/rvalid1/ram_wr/busy=%b, required 000000",
                  {gnt0, gnt1, rvalid0, rvalid1, ram_wr, busy});
      end
      do_reset();
   endtask

   task automatic test_contention();
      logic [1:0] exp;
      step();
      req0 = 1'b1; req1 = 1'b1; addr0 = 6'd1; addr1 = 6'd2;
      for (int i = 0; i < 4; i++) begin
         exp = (i % 2 == 0) ? 2'b01 : 2'b10;
         @(negedge clk);
         checks++;
         if ({gnt1, gnt0} !== exp) begin
            errors++;
            $display("FAIL contention[%0d]: {gnt1,gnt0}=%b, required %b", i, {gnt1, gnt0}, exp);
         end
         step();
      end
      idle_inputs();
      step();
      step();
      req0 = 1'b1; req1 = 1'b1;
      @(negedge clk);
      checks++;
      if ({gnt1, gnt0} !== 2'b01) begin
         errors++;
         $display("FAIL contention_after_idle: {gnt1,gnt0}=%b, required 01", {gnt1, gnt0});
      end
      step();
      idle_inputs();
   endtask

   task automatic test_single();
      logic [7:0] exp_d;
      step();
      for (int i = 0; i < 5; i++) begin
         req0 = 1'b1; we0 = 1'b1; addr0 = 6'(i); wdata0 = 8'(i + 1);
         @(negedge clk);
         checks++;
         if ({gnt0, gnt1, ram_wr, ram_add, ram_ip} !== {1'b1, 1'b0, 1'b1, 6'(i), 8'(i + 1)}) begin
            errors++;
            $display("FAIL single_write[%0d]: gnt0=%b gnt1=%b wr=%b add=%0d ip=%h, required 1 0 1 %0d %h",
                     i, gnt0, gnt1, ram_wr, ram_add, ram_ip, i, 8'(i + 1));
         end
         step();
      end
      for (int i = 0; i < 5; i++) begin
         we0 = 1'b0; addr0 = 6'(i);
         @(negedge clk);
         checks++;
         if (i == 0) begin
            if ({gnt0, ram_wr, rvalid0, rvalid1} !== 4'b1000) begin
               errors++;
               $display("FAIL single_read[0]: gnt0/wr/rvalid0/rvalid1=%b, required 1000",
                        {gnt0, ram_wr, rvalid0, rvalid1});
            end
         end else begin
            exp_d = 8'(i);
            if ({gnt0, ram_wr, rvalid0, rvalid1, rdata} !== {4'b1010, exp_d}) begin
               errors++;
               $display("FAIL single_read[%0d]: gnt0/wr/rvalid0/rvalid1=%b rdata=%h, required 1010 %h",
                        i, {gnt0, ram_wr, rvalid0, rvalid1}, rdata, exp_d);
            end
         end
         step();
      end
      idle_inputs();
      @(negedge clk);
      checks++;
      if ({gnt0, gnt1, ram_wr, rvalid0, rvalid1, rdata} !== {5'b00010, 8'h05}) begin
         errors++;
         $display("FAIL single_last_read: gnt0/gnt1/wr/rvalid0/rvalid1=%b rdata=%h, required 00010 05",
                  {gnt0, gnt1, ram_wr, rvalid0, rvalid1}, rdata);
      end
   endtask

   task automatic test_cross();
      step();
      req1 = 1'b1; we1 = 1'b1; addr1 = 6'd5; wdata1 = 8'h11;
      @(negedge clk);
      checks++;
      if ({gnt0, gnt1, ram_wr, ram_add, ram_ip} !== {3'b011, 6'd5, 8'h11}) begin
         errors++;
         $display("FAIL cross_write: gnt0=%b gnt1=%b wr=%b add=%0d ip=%h, required 0 1 1 5 11",
                  gnt0, gnt1, ram_wr, ram_add, ram_ip);
      end
      step();
      idle_inputs();
      req0 = 1'b1; addr0 = 6'd5;
      @(negedge clk);
      checks++;
      if ({gnt0, gnt1, ram_wr} !== 3'b100) begin
         errors++;
         $display("FAIL cross_read_grant: gnt0/gnt1/wr=%b, required 100", {gnt0, gnt1, ram_wr});
      end
      step();
      idle_inputs();
      @(negedge clk);
      checks++;
      if ({rvalid0, rvalid1, rdata} !== {2'b10, 8'h11}) begin
         errors++;
         $display("FAIL cross_read_data: rvalid0=%b rvalid1=%b rdata=%h, required 1 0 11",
                  rvalid0, rvalid1, rdata);
      end
   endtask

   task automatic test_reset_mid_read();
      step();
      req1 = 1'b1; addr1 = 6'd5;
      @(negedge clk);
      checks++;
      if ({gnt0, gnt1} !== 2'b01) begin
         errors++;
         $display("FAIL midread_grant: gnt0=%b gnt1=%b, required 0 1", gnt0, gnt1);
      end
      step();
      idle_inputs();
      req1 = 1'b1;
      rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if ({gnt0, gnt1, rvalid0, rvalid1, ram_wr, busy} !== 6'b0) begin
         errors++;
         $display("FAIL midread_reset: gnt0/gnt1/rvalid0/rvalid1/ram_wr/busy=%b, required 000000",
                  {gnt0, gnt1, rvalid0, rvalid1, ram_wr, busy});
      end
      step();
      idle_inputs();
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if ({rvalid0, rvalid1} !== 2'b00) begin
         errors++;
         $display("FAIL midread_release: rvalid0=%b rvalid1=%b, required 0 0", rvalid0, rvalid1);
      end
      do_reset();
   endtask

`ifdef RAM_ARB_CLEAR_EN
   task automatic test_clear();
      int busy_cnt;
      int first;
      int bad;
      rst_n = 1'b0;
      idle_inputs();
      step();
      step();
      req0 = 1'b1; addr0 = 6'd63;
      rst_n = 1'b1;
      busy_cnt = 0; first = 0; bad = 0;
      for (int c = 1; c <= 200; c++) begin
         @(negedge clk);
         if (busy) begin
            busy_cnt++;
            if ({ram_wr, ram_add, ram_ip, gnt0, gnt1} !== {1'b1, 6'(c - 1), 8'h00, 2'b00}) bad++;
         end
         if (gnt0 && first == 0) first = c;
         if (first != 0) break;
         step();
      end
      checks++;
      if (busy_cnt != 64) begin
         errors++;
         $display("FAIL clear_busy_len: %0d busy cycles, required 64", busy_cnt);
      end
      checks++;
      if (first != 65) begin
         errors++;
         $display("FAIL clear_first_grant: gnt0 first on cycle %0d, required 65", first);
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL clear_writes: %0d bad clear cycles, required 0", bad);
      end
      step();
      idle_inputs();
      @(negedge clk);
      checks++;
      if ({rvalid0, rdata} !== {1'b1, 8'h00}) begin
         errors++;
         $display("FAIL clear_readback: rvalid0=%b rdata=%h, required 1 00", rvalid0, rdata);
      end
   endtask
`endif

   initial begin
      idle_inputs();
      rst_n = 1'b0;
      test_reset();
      test_contention();
      test_single();
      test_cross();
      test_reset_mid_read();
`ifdef RAM_ARB_CLEAR_EN
      test_clear();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
